// File: rtl/csr_access_arbiter.sv
// Round-robin arbiter sharing the CSR register-map port between two host requesters.
// Optional macro CSR_ARB_ADDR_CHECK_EN: reject writes beyond the config register range.
module csr_access_arbiter #(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_CONFIG_REG = 96,
    parameter int WR_HOLD        = 3,
    parameter int RD_HOLD        = 3
) (
    input  logic                  clk_i,
    input  logic                  rstn_n,
    input  logic                  m0_valid_i,
    output logic                  m0_ready_o,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic                  m0_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] m0_rsp_rdata_o,
    output logic                  m0_rsp_err_o,
    input  logic                  m1_valid_i,
    output logic                  m1_ready_o,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic                  m1_rsp_valid_o,
    output logic [DATA_WIDTH-1:0] m1_rsp_rdata_o,
    output logic                  m1_rsp_err_o,
    output logic [ADDR_WIDTH-1:0] csr_addr_o,
    output logic [DATA_WIDTH-1:0] csr_wdata_o,
    output logic                  csr_we_o,
    output logic                  csr_re_o,
    input  logic [DATA_WIDTH-1:0] csr_rdata_i
);

    localparam int HOLD_MAX = (WR_HOLD > RD_HOLD) ? WR_HOLD : RD_HOLD;
    localparam int CNT_W    = $clog2(HOLD_MAX + 1);
    localparam logic [ADDR_WIDTH:0] CFG_LIMIT = (ADDR_WIDTH+1)'(NUM_CONFIG_REG);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    state_e           state_q, state_d;
    cmd_t             cmd_q;
    logic             gnt_q;
    logic             ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0] req_valid;
    cmd_t       req_cmd [2];
    logic       sel;
    cmd_t       sel_cmd;
    logic [1:0] ready;
    logic       accept;
    logic       addr_oob;
    logic       reject;
    logic       hold_last;
    logic [1:0] rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic       rsp_err;

    assign req_valid  = {m1_valid_i, m0_valid_i};
    assign req_cmd[0] = {m0_we_i, m0_addr_i, m0_wdata_i};
    assign req_cmd[1] = {m1_we_i, m1_addr_i, m1_wdata_i};

    // A lone requester wins outright; a tie goes to the priority pointer.
    always_comb begin
        sel = ptr_q;
        if (req_valid == 2'b01)
            sel = 1'b0;
        else if (req_valid == 2'b10)
            sel = 1'b1;
    end

    assign sel_cmd = req_cmd[sel];

    always_comb begin
        ready = '0;
        if (state_q == IDLE && req_valid[sel])
            ready[sel] = 1'b1;
    end

    assign accept   = |ready;
    assign addr_oob = sel_cmd.we && ({1'b0, sel_cmd.addr} >= CFG_LIMIT);

`ifdef CSR_ARB_ADDR_CHECK_EN
    logic err_q;
    assign reject = addr_oob;
`else
    logic unused_addr_oob;
    assign unused_addr_oob = addr_oob;
    assign reject          = 1'b0;
`endif

    assign hold_last = cmd_q.we ? (cnt_q == CNT_W'(WR_HOLD - 1))
                                : (cnt_q == CNT_W'(RD_HOLD - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = reject ? RESP : ACCESS;
            end
            ACCESS: begin
                if (hold_last)
                    state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_n) begin
        if (!rstn_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            gnt_q   <= 1'b0;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cmd_q <= sel_cmd;
                        gnt_q <= sel;
                        cnt_q <= '0;
                    end
                end
                ACCESS:  cnt_q <= cnt_q + CNT_W'(1);
                RESP:    ptr_q <= ~gnt_q;
                default: ;
            endcase
        end
    end

`ifdef CSR_ARB_ADDR_CHECK_EN
    always_ff @(posedge clk_i or negedge rstn_n) begin
        if (!rstn_n)
            err_q <= 1'b0;
        else if (state_q == IDLE && accept)
            err_q <= reject;
    end
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Address and data stay on the latched command between accesses; only enables fall.
    assign csr_addr_o  = cmd_q.addr;
    assign csr_wdata_o = cmd_q.wdata;
    assign csr_we_o    = (state_q == ACCESS) &&  cmd_q.we;
    assign csr_re_o    = (state_q == ACCESS) && !cmd_q.we;

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP)
            rsp_valid[gnt_q] = 1'b1;
    end

    // Rejected writes and all writes return zero data.
    assign rsp_rdata = (cmd_q.we || rsp_err) ? '0 : csr_rdata_i;

    assign m0_ready_o     = ready[0];
    assign m1_ready_o     = ready[1];
    assign m0_rsp_valid_o = rsp_valid[0];
    assign m1_rsp_valid_o = rsp_valid[1];
    assign m0_rsp_rdata_o = rsp_valid[0] ? rsp_rdata : '0;
    assign m1_rsp_rdata_o = rsp_valid[1] ? rsp_rdata : '0;
    assign m0_rsp_err_o   = rsp_valid[0] && rsp_err;
    assign m1_rsp_err_o   = rsp_valid[1] && rsp_err;

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Directed bench for csr_access_arbiter with a small register-map model on the CSR port.
module tb_csr_access_arbiter;

    logic       clk_i = 1'b0;
    logic       rstn_n;
    logic       m0_valid, m0_ready, m0_we, m0_rsp_valid, m0_rsp_err;
    logic [6:0] m0_addr;
    logic [7:0] m0_wdata, m0_rsp_rdata;
    logic       m1_valid, m1_ready, m1_we, m1_rsp_valid, m1_rsp_err;
    logic [6:0] m1_addr;
    logic [7:0] m1_wdata, m1_rsp_rdata;
    logic [6:0] csr_addr;
    logic [7:0] csr_wdata, csr_rdata;
    logic       csr_we, csr_re;

    int nerr = 0;
    int nchk = 0;

    always #5 clk_i = ~clk_i;

    csr_access_arbiter dut (
        .clk_i          (clk_i),
        .rstn_n         (rstn_n),
        .m0_valid_i     (m0_valid),
        .m0_ready_o     (m0_ready),
        .m0_we_i        (m0_we),
        .m0_addr_i      (m0_addr),
        .m0_wdata_i     (m0_wdata),
        .m0_rsp_valid_o (m0_rsp_valid),
        .m0_rsp_rdata_o (m0_rsp_rdata),
        .m0_rsp_err_o   (m0_rsp_err),
        .m1_valid_i     (m1_valid),
        .m1_ready_o     (m1_ready),
        .m1_we_i        (m1_we),
        .m1_addr_i      (m1_addr),
        .m1_wdata_i     (m1_wdata),
        .m1_rsp_valid_o (m1_rsp_valid),
        .m1_rsp_rdata_o (m1_rsp_rdata),
        .m1_rsp_err_o   (m1_rsp_err),
        .csr_addr_o     (csr_addr),
        .csr_wdata_o    (csr_wdata),
        .csr_we_o       (csr_we),
        .csr_re_o       (csr_re),
        .csr_rdata_i    (csr_rdata)
    );

    // Register map: 96 config registers, register 0 resets to 0xCC, unmapped reads 0xFF.
    logic [7:0] mem [0:95];
    always @(posedge clk_i) begin
        if (!rstn_n) begin
            for (int i = 0; i < 96; i++) mem[i] <= 8'h00;
            mem[0] <= 8'hCC;
        end else if (csr_we && csr_addr < 7'd96) begin
            mem[csr_addr] <= csr_wdata;
        end
    end
    assign csr_rdata = (csr_addr < 7'd96) ? mem[csr_addr] : 8'hFF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command and check handshake, enable window and response strobe.
    task automatic do_access(input int m, input logic we, input logic [6:0] addr,
                             input logic [7:0] wd, input logic [7:0] exp_rd,
                             input logic exp_err, input int hold, input string tag);
        int n;
        logic rdy;
        if (m == 0) begin m0_valid = 1; m0_we = we; m0_addr = addr; m0_wdata = wd; end
        else        begin m1_valid = 1; m1_we = we; m1_addr = addr; m1_wdata = wd; end
        n = 0;
        @(negedge clk_i);
        rdy = (m == 0) ? m0_ready : m1_ready;
        while (!rdy && n < 20) begin
            @(negedge clk_i);
            n++;
            rdy = (m == 0) ? m0_ready : m1_ready;
        end
        chk({tag, "_ready"}, {31'd0, rdy}, 1);
        @(posedge clk_i); #1;
        m0_valid = 0; m1_valid = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            chk({tag, "_en"}, {30'd0, csr_we, csr_re}, we ? 2'b10 : 2'b01);
            chk({tag, "_addr"}, {25'd0, csr_addr}, {25'd0, addr});
        end
        @(negedge clk_i);
        chk({tag, "_rspv"}, {30'd0, m1_rsp_valid, m0_rsp_valid}, (m == 0) ? 2'b01 : 2'b10);
        chk({tag, "_rdata"}, {24'd0, (m == 0) ? m0_rsp_rdata : m1_rsp_rdata}, {24'd0, exp_rd});
        chk({tag, "_err"}, {31'd0, (m == 0) ? m0_rsp_err : m1_rsp_err}, {31'd0, exp_err});
        chk({tag, "_en_off"}, {30'd0, csr_we, csr_re}, 0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        int grants [4];
        int gcnt;
        int n;
        logic oob_err;
        int   oob_hold;

        rstn_n = 0;
        m0_valid = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_valid = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        repeat (3) @(posedge clk_i);
        #1 rstn_n = 1;

        // Reset state
        @(negedge clk_i);
        chk("rst_ready", {30'd0, m1_ready, m0_ready}, 0);
        chk("rst_rspv",  {30'd0, m1_rsp_valid, m0_rsp_valid}, 0);
        chk("rst_en",    {30'd0, csr_we, csr_re}, 0);
        chk("rst_addr",  {25'd0, csr_addr}, 0);
        chk("rst_wdata", {24'd0, csr_wdata}, 0);

        // Read of register 0 returns its reset value
        do_access(0, 0, 7'h00, 8'h00, 8'hCC, 0, 3, "rd0");

        // Write then read back from the other requester
        do_access(0, 1, 7'h05, 8'hA5, 8'h00, 0, 3, "wr5");
        @(negedge clk_i);
        chk("idle_addr_hold",  {25'd0, csr_addr}, 32'h05);
        chk("idle_wdata_hold", {24'd0, csr_wdata}, 32'hA5);
        chk("idle_en",         {30'd0, csr_we, csr_re}, 0);
        do_access(1, 0, 7'h05, 8'h00, 8'hA5, 0, 3, "rd5");

        // Unmapped read passes the map's 0xFF through
        do_access(1, 0, 7'h7F, 8'h00, 8'hFF, 0, 3, "rd7f");

        // Out-of-range write
`ifdef CSR_ARB_ADDR_CHECK_EN
        oob_err = 1; oob_hold = 0;
`else
        oob_err = 0; oob_hold = 3;
`endif
        do_access(0, 1, 7'h60, 8'h5A, 8'h00, oob_err, oob_hold, "wr60");

        // Reset in the middle of a write; pointer currently favours m1
        m1_valid = 1; m1_we = 1; m1_addr = 7'h03; m1_wdata = 8'h33;
        @(negedge clk_i);
        chk("mid_ready", {31'd0, m1_ready}, 1);
        @(posedge clk_i); #1;
        m1_valid = 0;
        @(negedge clk_i);
        chk("mid_we_on", {31'd0, csr_we}, 1);
        #2 rstn_n = 0;
        #1;
        chk("mid_we_drop", {30'd0, csr_we, csr_re}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("mid_no_rsp", {30'd0, m1_rsp_valid, m0_rsp_valid}, 0);
        end
        @(posedge clk_i); #1 rstn_n = 1;

        // Both valid continuously: grants alternate starting from m0
        m0_valid = 1; m0_we = 0; m0_addr = 7'h01; m0_wdata = 0;
        m1_valid = 1; m1_we = 0; m1_addr = 7'h02; m1_wdata = 0;
        gcnt = 0;
        n = 0;
        while (gcnt < 4 && n < 60) begin
            @(negedge clk_i);
            n++;
            if (m0_ready && m1_ready) chk("rr_both_ready", 2'b11, 2'b01);
            if (m0_ready)      begin grants[gcnt] = 0; gcnt++; end
            else if (m1_ready) begin grants[gcnt] = 1; gcnt++; end
        end
        @(posedge clk_i); #1;
        m0_valid = 0; m1_valid = 0;
        chk("rr_count", gcnt, 4);
        for (int k = 0; k < gcnt; k++)
            chk($sformatf("rr_grant%0d", k), grants[k], k % 2);
        repeat (6) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("end_idle_en", {30'd0, csr_we, csr_re}, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
